demux16_deserializer: RTL

// - Receive-side counterpart of the 16-to-1 select path: rebuilds a WIDTH-bit word

---
 rtl/demux16_deserializer.sv | 94 +++++++++
 1 files changed

// File: rtl/demux16_deserializer.sv
// Serial-to-parallel word builder: each accepted bit is demuxed into an assembly
// register, and completed words are handed off through a valid/ready output stage.
module demux16_deserializer #(
  parameter int WIDTH     = 16,
  parameter int SEL_W     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, FILL, STALL} state_t;

  localparam logic [SEL_W-1:0] LAST = SEL_W'(WIDTH - 1);

  state_t           state, state_n;
  logic [SEL_W-1:0] cnt;
  logic [WIDTH-1:0] asm_q;
  logic [WIDTH-1:0] word;
  logic             is_last;
  logic             accept;

  // Only the closing bit is held back, and only while the previous word is unread.
  always_comb begin
    is_last   = (cnt == LAST);
    din_ready = !clear && !(is_last && dout_valid && !dout_ready);
    accept    = din_valid && din_ready;
    sel       = MSB_FIRST ? (LAST - cnt) : cnt;
    word      = asm_q;
    word[sel] = din;
  end

  assign busy = (state != IDLE);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:        if (accept) state_n = FILL;
      FILL, STALL: begin
        if (accept && is_last)         state_n = IDLE;
        else if (is_last && !din_ready) state_n = STALL;
        else                           state_n = FILL;
      end
      default:     state_n = IDLE;
    endcase
    if (clear) state_n = IDLE;
  end

  // Assembly path: clear beats a same-cycle accept because din_ready is low then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      asm_q <= '0;
    end else begin
      state <= state_n;
      if (clear) begin
        cnt   <= '0;
        asm_q <= '0;
      end else if (accept) begin
        if (is_last) begin
          cnt   <= '0;
          asm_q <= '0;
        end else begin
          cnt        <= cnt + SEL_W'(1);
          asm_q[sel] <= din;
        end
      end
    end
  end

  // A completing word may replace one consumed on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (accept && is_last) begin
      dout       <= word;
      dout_valid <= 1'b1;
    end else if (dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

endmodule
